data_mem_ctrl: RTL and testbench



---
 rtl/data_mem_ctrl_if.sv | 53 +++++
 rtl/data_mem_ctrl.sv | 273 +++++++++++++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_ctrl_if.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl_if
// Request/response bus between the CPU load/store path and data_mem_ctrl.
//
// Parameters:
//   XLEN   - data width in bits (32 or 64)
//   ADDR_W - byte address width in bits
//
// Signals:
//   req_valid    request present                     (master -> slave)
//   req_ready    controller can accept a request     (slave  -> master)
//   req_write    1 = store, 0 = load                 (master -> slave)
//   req_addr     byte address                        (master -> slave)
//   req_size     0 byte, 1 half, 2 word, 3 dword     (master -> slave)
//   req_unsigned load zero-extends when 1            (master -> slave)
//   req_wdata    store data, right-justified         (master -> slave)
//   rsp_valid    response present                    (slave  -> master)
//   rsp_ready    consumer accepts the response       (master -> slave)
//   rsp_rdata    load result, 0 for stores/errors    (slave  -> master)
//   rsp_err      misaligned or out-of-range request  (slave  -> master)
// -----------------------------------------------------------------------------
interface data_mem_ctrl_if #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 32
);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [XLEN-1:0]   req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [XLEN-1:0]   rsp_rdata;
  logic              rsp_err;

  // CPU side: issues requests, consumes responses
  modport master (
    output req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  // Controller side
  modport slave (
    input  req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl
// Multi-cycle data-memory controller for the CPU load/store path. Accepts
// byte/half/word/dword loads and stores over a valid/ready request channel and
// answers over a valid/ready response channel LATENCY cycles after accept.
// Checks alignment and address range, merges store byte lanes and sign/zero
// extends loads. One request is in flight at a time.
//
// Parameters:
//   XLEN    - data width (32 or 64)
//   DEPTH   - number of XLEN-wide words in the array
//   ADDR_W  - byte address width
//   LATENCY - accept-to-rsp_valid latency in cycles (1..15)
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   asynchronous active-low reset
//   bus    slave modport of data_mem_ctrl_if (request/response channels)
//   busy   out  high whenever the controller is not idle
//
// Optional feature (macro DMEM_PERF_EN):
//   perf_loads / perf_stores / perf_errs  out [31:0] saturating counters of
//   completed loads, stores and errored requests (counted on the response
//   handshake; errored requests count only in perf_errs).
// -----------------------------------------------------------------------------
module data_mem_ctrl #(
  parameter int XLEN    = 64,
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  data_mem_ctrl_if.slave    bus,
  output logic              busy
`ifdef DMEM_PERF_EN
  ,
  output logic [31:0]       perf_loads,
  output logic [31:0]       perf_stores,
  output logic [31:0]       perf_errs
`endif
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  // WAIT spends LATENCY cycles in total, so the counter starts at LATENCY-1
  // and the access executes on the edge where it reads zero.
  localparam logic [3:0]        LAT_M1  = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Shift the selected lanes down already, then mask and extend to XLEN.
  // Sizes that cover the whole word use an all-ones mask, so no extension.
  function automatic logic [XLEN-1:0] load_extend(
    input logic [XLEN-1:0] raw,
    input logic [1:0]      size,
    input logic            uns
  );
    logic [XLEN-1:0] mask;
    logic            sign;
    case (size)
      2'd0: begin
        mask = XLEN'(8'hFF);
        sign = raw[7];
      end
      2'd1: begin
        mask = XLEN'(16'hFFFF);
        sign = raw[15];
      end
      2'd2: begin
        mask = XLEN'(32'hFFFF_FFFF);
        sign = raw[31];
      end
      default: begin
        mask = '1;
        sign = 1'b0;
      end
    endcase
    return (raw & mask) | ((sign & ~uns) ? ~mask : '0);
  endfunction

  // Byte-enable pattern for a size, before shifting to the lane offset.
  function automatic logic [NB-1:0] size_bytes(input logic [1:0] size);
    logic [NB-1:0] be;
    case (size)
      2'd0:    be = NB'(8'h01);
      2'd1:    be = NB'(8'h03);
      2'd2:    be = NB'(8'h0F);
      default: be = NB'(8'hFF);
    endcase
    return be;
  endfunction

  state_t            state_r;
  logic [3:0]        cnt_r;
  logic              req_ready_r;
  logic              rsp_valid_r;
  logic [XLEN-1:0]   rsp_rdata_r;
  logic              rsp_err_r;
  logic              busy_r;

  // Captured request
  logic              wr_r;
  logic [ADDR_W-1:0] addr_r;
  logic [1:0]        size_r;
  logic              uns_r;
  logic [XLEN-1:0]   wdata_r;

  logic [XLEN-1:0]   mem_r [DEPTH];

  logic [OFF_W-1:0]  lane_s;
  logic [IDX_W-1:0]  idx_s;
  logic [ADDR_W-1:0] word_idx_s;
  logic              misalign_s;
  logic              range_err_s;
  logic              size_err_s;
  logic              err_s;
  logic [NB-1:0]     be_s;
  logic [XLEN-1:0]   wshift_s;
  logic [XLEN-1:0]   rd_word_s;
  logic [XLEN-1:0]   load_s;
  logic              exec_s;
  logic              mem_we_s;
  logic              accept_s;
  logic              rsp_hs_s;

  assign accept_s = (state_r == S_IDLE) && bus.req_valid && req_ready_r;
  assign rsp_hs_s = (state_r == S_RESP) && bus.rsp_ready;
  assign exec_s   = (state_r == S_WAIT) && (cnt_r == 4'd0);

  // Address decode, error detection and lane shifting of the captured request
  always_comb begin
    lane_s      = addr_r[OFF_W-1:0];
    idx_s       = addr_r[OFF_W +: IDX_W];
    word_idx_s  = addr_r >> OFF_W;
    case (size_r)
      2'd0:    misalign_s = 1'b0;
      2'd1:    misalign_s = addr_r[0];
      2'd2:    misalign_s = |addr_r[1:0];
      2'd3:    misalign_s = |addr_r[2:0];
      default: misalign_s = 1'b1;
    endcase
    range_err_s = (word_idx_s >= DEPTH_A);
    size_err_s  = (size_r == 2'd3) && (XLEN == 32);
    err_s       = misalign_s | range_err_s | size_err_s;
    be_s        = size_bytes(size_r) << lane_s;
    wshift_s    = wdata_r << {lane_s, 3'b000};
    rd_word_s   = mem_r[idx_s];
    load_s      = load_extend(rd_word_s >> {lane_s, 3'b000}, size_r, uns_r);
    mem_we_s    = exec_s && wr_r && !err_s;
  end

  // Control FSM with registered handshake/status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= S_IDLE;
      cnt_r       <= 4'd0;
      req_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= '0;
      rsp_err_r   <= 1'b0;
      busy_r      <= 1'b0;
      wr_r        <= 1'b0;
      addr_r      <= '0;
      size_r      <= 2'd0;
      uns_r       <= 1'b0;
      wdata_r     <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            wr_r        <= bus.req_write;
            addr_r      <= bus.req_addr;
            size_r      <= bus.req_size;
            uns_r       <= bus.req_unsigned;
            wdata_r     <= bus.req_wdata;
            cnt_r       <= LAT_M1;
            state_r     <= S_WAIT;
            req_ready_r <= 1'b0;
            busy_r      <= 1'b1;
          end else begin
            // Also raises req_ready on the first edge after reset release
            req_ready_r <= 1'b1;
          end
        end
        S_WAIT: begin
          if (exec_s) begin
            state_r     <= S_RESP;
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= err_s;
            rsp_rdata_r <= (err_s || wr_r) ? '0 : load_s;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_hs_s) begin
            state_r     <= S_IDLE;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= '0;
            rsp_err_r   <= 1'b0;
            busy_r      <= 1'b0;
            req_ready_r <= 1'b1;
          end else begin
            rsp_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= S_IDLE;
          rsp_valid_r <= 1'b0;
          rsp_rdata_r <= '0;
          rsp_err_r   <= 1'b0;
          busy_r      <= 1'b0;
          req_ready_r <= 1'b0;
        end
      endcase
    end
  end

  // Storage array: only enabled byte lanes of a non-errored store change.
  // Not reset; a reset before the commit edge leaves the FSM idle, so a
  // pending store is simply never written.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int b = 0; b < NB; b++) begin
        if (be_s[b]) begin
          mem_r[idx_s][b*8 +: 8] <= wshift_s[b*8 +: 8];
        end
      end
    end
  end

  assign bus.req_ready = req_ready_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_rdata = rsp_rdata_r;
  assign bus.rsp_err   = rsp_err_r;
  assign busy          = busy_r;

`ifdef DMEM_PERF_EN
  logic [31:0] perf_loads_r;
  logic [31:0] perf_stores_r;
  logic [31:0] perf_errs_r;

  // Saturating performance counters, updated on the response handshake
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_loads_r  <= 32'd0;
      perf_stores_r <= 32'd0;
      perf_errs_r   <= 32'd0;
    end else if (rsp_hs_s) begin
      if (rsp_err_r) begin
        if (perf_errs_r != 32'hFFFF_FFFF) perf_errs_r <= perf_errs_r + 32'd1;
      end else if (wr_r) begin
        if (perf_stores_r != 32'hFFFF_FFFF) perf_stores_r <= perf_stores_r + 32'd1;
      end else begin
        if (perf_loads_r != 32'hFFFF_FFFF) perf_loads_r <= perf_loads_r + 32'd1;
      end
    end
  end

  assign perf_loads  = perf_loads_r;
  assign perf_stores = perf_stores_r;
  assign perf_errs   = perf_errs_r;
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_data_mem_ctrl
// Scoreboard bench for data_mem_ctrl (XLEN=64, DEPTH=256, LATENCY=2).
// Expected responses are queued when a request is driven and compared when
// the controller presents rsp_valid.
// -----------------------------------------------------------------------------
module tb_data_mem_ctrl;

  logic clk;
  logic reset;
  logic busy;
`ifdef DMEM_PERF_EN
  logic [31:0] perf_loads;
  logic [31:0] perf_stores;
  logic [31:0] perf_errs;
`endif

  data_mem_ctrl_if #(.XLEN(64), .ADDR_W(32)) bus ();

  data_mem_ctrl #(
    .XLEN(64), .DEPTH(256), .ADDR_W(32), .LATENCY(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
`ifdef DMEM_PERF_EN
    ,
    .perf_loads  (perf_loads),
    .perf_stores (perf_stores),
    .perf_errs   (perf_errs)
`endif
  );

  typedef struct packed {
    logic [63:0] d;
    logic        e;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic w, input logic [31:0] a, input logic [1:0] s,
                           input logic u, input logic [63:0] wd,
                           input logic [63:0] exp_d, input logic exp_e);
    exp_t x;
    x.d = exp_d;
    x.e = exp_e;
    sb_q.push_back(x);
    bus.req_write    = w;
    bus.req_addr     = a;
    bus.req_size     = s;
    bus.req_unsigned = u;
    bus.req_wdata    = wd;
    bus.req_valid    = 1'b1;
  endtask

  task automatic wait_accept(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus.req_ready) ok = 1'b1;
    end
    if (!ok) check_val({tag, "_accept_timeout"}, 64'd0, 64'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  // Counts edges from accept to rsp_valid, compares against the scoreboard,
  // and completes the handshake if rsp_ready is high.
  task automatic wait_rsp(input string tag);
    int   lat = 0;
    bit   got = 1'b0;
    exp_t x;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.rsp_valid) got = 1'b1;
    end
    check_val({tag, "_lat"}, 64'(lat), 64'd2);
    if (got) begin
      if (sb_q.size() == 0) begin
        check_val({tag, "_sb_empty"}, 64'd0, 64'd1);
      end else begin
        x = sb_q.pop_front();
        check_val({tag, "_rdata"}, bus.rsp_rdata, x.d);
        check_val({tag, "_err"}, 64'(bus.rsp_err), 64'(x.e));
      end
      if (bus.rsp_ready) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic xact(input string tag, input logic w, input logic [31:0] a,
                      input logic [1:0] s, input logic u, input logic [63:0] wd,
                      input logic [63:0] exp_d, input logic exp_e);
    drive_req(w, a, s, u, wd, exp_d, exp_e);
    wait_accept(tag);
    wait_rsp(tag);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    sb_q.delete();
    @(negedge clk);
  endtask

  // Global time limit
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset            = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_addr     = 32'd0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_wdata    = 64'd0;
    bus.rsp_ready    = 1'b1;

    // Reset state
    #12;
    check_val("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check_val("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check_val("rst_rdata", bus.rsp_rdata, 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_val("rst_ready_rise", 64'(bus.req_ready), 64'd1);
    @(posedge clk);
    #1;

    // 1: dword store/load round trip
    xact("t1_st", 1'b1, 32'h10, 2'd3, 1'b0, 64'h1122334455667788, 64'd0, 1'b0);
    xact("t1_ld", 1'b0, 32'h10, 2'd3, 1'b0, 64'd0, 64'h1122334455667788, 1'b0);

    // 2: byte merge and extension
    xact("t2_stb", 1'b1, 32'h13, 2'd0, 1'b0, 64'h80, 64'd0, 1'b0);
    xact("t2_lbs", 1'b0, 32'h13, 2'd0, 1'b0, 64'd0, 64'hFFFFFFFFFFFFFF80, 1'b0);
    xact("t2_lbu", 1'b0, 32'h13, 2'd0, 1'b1, 64'd0, 64'h80, 1'b0);
    xact("t2_ld",  1'b0, 32'h10, 2'd3, 1'b0, 64'd0, 64'h1122334480667788, 1'b0);
    xact("t2_lhs", 1'b0, 32'h12, 2'd1, 1'b0, 64'd0, 64'hFFFFFFFFFFFF8066, 1'b0);
    xact("t2_lwu", 1'b0, 32'h14, 2'd2, 1'b1, 64'd0, 64'h11223344, 1'b0);

    // 3: error cases leave memory untouched
    xact("t3_mis",  1'b0, 32'h12,  2'd2, 1'b0, 64'd0, 64'd0, 1'b1);
    xact("t3_sth",  1'b1, 32'h801, 2'd1, 1'b0, 64'hFFFF, 64'd0, 1'b1);
    xact("t3_oor",  1'b1, 32'h800, 2'd3, 1'b0, 64'hDEADBEEF, 64'd0, 1'b1);
    xact("t3_mis2", 1'b1, 32'h14,  2'd3, 1'b0, 64'hDEADBEEF, 64'd0, 1'b1);
    xact("t3_ld",   1'b0, 32'h10,  2'd3, 1'b0, 64'd0, 64'h1122334480667788, 1'b0);

    // 4: response backpressure with a held request
    bus.rsp_ready = 1'b0;
    drive_req(1'b0, 32'h10, 2'd3, 1'b0, 64'd0, 64'h1122334480667788, 1'b0);
    wait_accept("t4_a");
    wait_rsp("t4_a");
    drive_req(1'b0, 32'h13, 2'd0, 1'b1, 64'd0, 64'h80, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_val("t4_hold_valid", 64'(bus.rsp_valid), 64'd1);
      check_val("t4_hold_rdata", bus.rsp_rdata, 64'h1122334480667788);
      check_val("t4_hold_err", 64'(bus.rsp_err), 64'd0);
      check_val("t4_hold_ready", 64'(bus.req_ready), 64'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val("t4_after_ready", 64'(bus.req_ready), 64'd1);
    check_val("t4_after_valid", 64'(bus.rsp_valid), 64'd0);
    check_val("t4_after_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check_val("t4_held_busy", 64'(busy), 64'd1);
    wait_rsp("t4_held");

    // 5: reset during WAIT drops the pending store
    xact("t5_st", 1'b1, 32'h20, 2'd3, 1'b0, 64'hAAAA, 64'd0, 1'b0);
    drive_req(1'b1, 32'h20, 2'd3, 1'b0, 64'h5555, 64'd0, 1'b0);
    wait_accept("t5_drop");
    @(negedge clk);
    check_val("t5_wait_busy", 64'(busy), 64'd1);
    #1;
    reset = 1'b0;
    #1;
    check_val("t5_rst_busy", 64'(busy), 64'd0);
    check_val("t5_rst_valid", 64'(bus.rsp_valid), 64'd0);
    check_val("t5_rst_ready", 64'(bus.req_ready), 64'd0);
    check_val("t5_rst_rdata", bus.rsp_rdata, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    sb_q.delete();
    @(negedge clk);
    check_val("t5_ready_rise", 64'(bus.req_ready), 64'd1);
    @(posedge clk);
    #1;
    xact("t5_ld", 1'b0, 32'h20, 2'd3, 1'b0, 64'd0, 64'hAAAA, 1'b0);

`ifdef DMEM_PERF_EN
    // 6: performance counters
    apply_reset();
    check_val("t6_rst_loads", 64'(perf_loads), 64'd0);
    check_val("t6_rst_stores", 64'(perf_stores), 64'd0);
    check_val("t6_rst_errs", 64'(perf_errs), 64'd0);
    @(posedge clk);
    #1;
    xact("t6_ld1", 1'b0, 32'h20, 2'd3, 1'b0, 64'd0, 64'hAAAA, 1'b0);
    xact("t6_ld2", 1'b0, 32'h10, 2'd3, 1'b0, 64'd0, 64'h1122334480667788, 1'b0);
    xact("t6_st",  1'b1, 32'h30, 2'd2, 1'b0, 64'h12345678, 64'd0, 1'b0);
    xact("t6_mis", 1'b0, 32'h31, 2'd1, 1'b0, 64'd0, 64'd0, 1'b1);
    check_val("t6_loads", 64'(perf_loads), 64'd2);
    check_val("t6_stores", 64'(perf_stores), 64'd1);
    check_val("t6_errs", 64'(perf_errs), 64'd1);
    apply_reset();
    check_val("t6_clr_loads", 64'(perf_loads), 64'd0);
    check_val("t6_clr_stores", 64'(perf_stores), 64'd0);
    check_val("t6_clr_errs", 64'(perf_errs), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
